mc_regalu_core: RTL and testbench

Parametrised multicycle register-file/ALU core: the next generation of the fixed 32-bit IR -> register file -> A/B latch -> ALU source mux -> ALU datapath. It adds an internal sequencing FSM, a valid/ready instruction handshake, configurable data width and register count, signed-overflow detection and a JAL link path. It sits between the fetch logic, which supplies instruction words and the PC, and the memory/branch logic, which consumes `result` and `zero`.

---
 rtl/mc_regalu_core_if.sv | 62 ++++++
 rtl/mc_regalu_core.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_mc_regalu_core.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_regalu_core_if.sv
// -----------------------------------------------------------------------------
// mc_regalu_core_if
// Instruction handshake, result bus and debug read port of mc_regalu_core.
//
// Signals:
//   instr_in    [31:0]      instruction word from fetch
//   instr_valid             instr_in / pc_in are valid
//   instr_ready             core is in IDLE and can accept an instruction
//   pc_in       [WIDTH-1:0] PC of the offered instruction
//   result      [WIDTH-1:0] registered ALU output
//   zero                    result == 0, registered with result
//   overflow                signed overflow of add/sub/addi, registered with result
//   done                    one-cycle pulse in WRITEBACK
//   illegal                 one-cycle pulse in WRITEBACK for an unsupported encoding
//   dbg_addr    [4:0]       debug register index
//   dbg_data    [WIDTH-1:0] combinational read of register dbg_addr
//
// Modports: master = fetch / memory side, slave = the core.
// -----------------------------------------------------------------------------
interface mc_regalu_core_if #(
   parameter int WIDTH = 32
);
   logic [31:0]      instr_in;
   logic             instr_valid;
   logic             instr_ready;
   logic [WIDTH-1:0] pc_in;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;
   logic             done;
   logic             illegal;
   logic [4:0]       dbg_addr;
   logic [WIDTH-1:0] dbg_data;

   modport master (
      output instr_in,
      output instr_valid,
      output pc_in,
      output dbg_addr,
      input  instr_ready,
      input  result,
      input  zero,
      input  overflow,
      input  done,
      input  illegal,
      input  dbg_data
   );

   modport slave (
      input  instr_in,
      input  instr_valid,
      input  pc_in,
      input  dbg_addr,
      output instr_ready,
      output result,
      output zero,
      output overflow,
      output done,
      output illegal,
      output dbg_data
   );
endinterface

// File: rtl/mc_regalu_core.sv
// -----------------------------------------------------------------------------
// mc_regalu_core
// Multicycle register-file / ALU core. Each instruction goes through
// IDLE -> DECODE -> EXECUTE -> WRITEBACK, one state per clock, so a new
// instruction can be accepted every fourth cycle.
//
// Parameters:
//   WIDTH  datapath / register width (16..64)
//   NREGS  register count (8, 16 or 32); register indices use the low
//          log2(NREGS) bits of each 5-bit instruction field
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    mc_regalu_core_if.slave: instruction handshake, PC, registered
//          result/zero/overflow, done/illegal pulses and debug read port
//
// Supported encodings: R-type add/sub/and/or/xor/slt, addi, andi, ori, jal.
// Anything else completes as an illegal instruction with no register write.
// -----------------------------------------------------------------------------
module mc_regalu_core #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             reset,
   mc_regalu_core_if.slave  bus
);

   localparam int            AW       = $clog2(NREGS);
   localparam int            MSB      = WIDTH - 1;
   localparam logic [AW-1:0] LINK_IDX = AW'(NREGS - 1);
   localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DECODE    = 2'd1,
      ST_EXECUTE   = 2'd2,
      ST_WRITEBACK = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5
   } alu_op_t;

   typedef enum logic [1:0] {
      SRC_B_REG  = 2'd0,
      SRC_B_SIMM = 2'd1,
      SRC_B_ZIMM = 2'd2,
      SRC_B_FOUR = 2'd3
   } src_b_t;

   // Sequencing state and architectural latches
   state_t           state_r;
   logic [31:0]      ir_r;
   logic [WIDTH-1:0] pc_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] result_r;
   logic             zero_r;
   logic             overflow_r;
   logic             done_r;
   logic             illegal_r;
   logic             ready_r;
   logic [WIDTH-1:0] regs_r [NREGS];

   // Instruction fields
   logic [5:0]       op_s;
   logic [5:0]       funct_s;
   logic [4:0]       rs_f_s;
   logic [4:0]       rt_f_s;
   logic [4:0]       rd_f_s;
   logic [15:0]      imm_s;

   // Decode results
   alu_op_t          alu_op_s;
   src_b_t           src_b_sel_s;
   logic             src_a_pc_s;
   logic             ovf_en_s;
   logic             legal_s;
   logic [AW-1:0]    dest_s;

   // ALU datapath
   logic [WIDTH-1:0] src_a_v_s;
   logic [WIDTH-1:0] src_b_v_s;
   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] diff_s;
   logic             slt_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_ovf_s;

   // Field bits that this configuration never consumes (shamt, and the high
   // index bits when NREGS < 32) are gathered here on purpose.
   logic             unused_ok_s;

   assign op_s    = ir_r[31:26];
   assign rs_f_s  = ir_r[25:21];
   assign rt_f_s  = ir_r[20:16];
   assign rd_f_s  = ir_r[15:11];
   assign funct_s = ir_r[5:0];
   assign imm_s   = ir_r[15:0];

   assign unused_ok_s = ^{ir_r[10:6], rs_f_s, rt_f_s, rd_f_s, bus.dbg_addr};

   // Instruction decode: ALU operation, operand sources, destination, legality
   always_comb begin
      alu_op_s    = ALU_ADD;
      src_b_sel_s = SRC_B_REG;
      src_a_pc_s  = 1'b0;
      ovf_en_s    = 1'b0;
      legal_s     = 1'b1;
      dest_s      = rd_f_s[AW-1:0];
      case (op_s)
         OP_RTYPE: begin
            case (funct_s)
               FN_ADD: begin
                  alu_op_s = ALU_ADD;
                  ovf_en_s = 1'b1;
               end
               FN_SUB: begin
                  alu_op_s = ALU_SUB;
                  ovf_en_s = 1'b1;
               end
               FN_AND:  alu_op_s = ALU_AND;
               FN_OR:   alu_op_s = ALU_OR;
               FN_XOR:  alu_op_s = ALU_XOR;
               FN_SLT:  alu_op_s = ALU_SLT;
               default: legal_s  = 1'b0;
            endcase
         end
         OP_ADDI: begin
            alu_op_s    = ALU_ADD;
            src_b_sel_s = SRC_B_SIMM;
            ovf_en_s    = 1'b1;
            dest_s      = rt_f_s[AW-1:0];
         end
         OP_ANDI: begin
            alu_op_s    = ALU_AND;
            src_b_sel_s = SRC_B_ZIMM;
            dest_s      = rt_f_s[AW-1:0];
         end
         OP_ORI: begin
            alu_op_s    = ALU_OR;
            src_b_sel_s = SRC_B_ZIMM;
            dest_s      = rt_f_s[AW-1:0];
         end
         OP_JAL: begin
            // Link address is computed by the ALU adder as PC + 4; never flags overflow
            alu_op_s    = ALU_ADD;
            src_a_pc_s  = 1'b1;
            src_b_sel_s = SRC_B_FOUR;
            dest_s      = LINK_IDX;
         end
         default: legal_s = 1'b0;
      endcase
   end

   // ALU source selection
   always_comb begin
      src_a_v_s = src_a_pc_s ? pc_r : a_r;
      case (src_b_sel_s)
         SRC_B_REG:  src_b_v_s = b_r;
         SRC_B_SIMM: src_b_v_s = WIDTH'($signed(imm_s));
         SRC_B_ZIMM: src_b_v_s = WIDTH'(imm_s);
         SRC_B_FOUR: src_b_v_s = WIDTH'(32'd4);
         default:    src_b_v_s = b_r;
      endcase
   end

   assign sum_s  = src_a_v_s + src_b_v_s;
   assign diff_s = src_a_v_s - src_b_v_s;
   assign slt_s  = $signed(src_a_v_s) < $signed(src_b_v_s);

   // ALU function and signed-overflow detection
   always_comb begin
      alu_res_s = sum_s;
      alu_ovf_s = 1'b0;
      case (alu_op_s)
         ALU_ADD: begin
            alu_res_s = sum_s;
            // same-sign operands producing a result of the other sign
            alu_ovf_s = ovf_en_s & (src_a_v_s[MSB] == src_b_v_s[MSB]) &
                        (sum_s[MSB] != src_a_v_s[MSB]);
         end
         ALU_SUB: begin
            alu_res_s = diff_s;
            // opposite-sign operands where the result takes the subtrahend's sign
            alu_ovf_s = ovf_en_s & (src_a_v_s[MSB] != src_b_v_s[MSB]) &
                        (diff_s[MSB] != src_a_v_s[MSB]);
         end
         ALU_AND: alu_res_s = src_a_v_s & src_b_v_s;
         ALU_OR:  alu_res_s = src_a_v_s | src_b_v_s;
         ALU_XOR: alu_res_s = src_a_v_s ^ src_b_v_s;
         ALU_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
         default: begin
            alu_res_s = sum_s;
            alu_ovf_s = 1'b0;
         end
      endcase
   end

   // Sequencing FSM with IR/PC/A/B latches and registered status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         ir_r       <= 32'h0000_0000;
         pc_r       <= {WIDTH{1'b0}};
         a_r        <= {WIDTH{1'b0}};
         b_r        <= {WIDTH{1'b0}};
         result_r   <= {WIDTH{1'b0}};
         zero_r     <= 1'b1;
         overflow_r <= 1'b0;
         done_r     <= 1'b0;
         illegal_r  <= 1'b0;
         ready_r    <= 1'b1;
      end else begin
         done_r    <= 1'b0;
         illegal_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.instr_valid) begin
                  ir_r    <= bus.instr_in;
                  pc_r    <= bus.pc_in;
                  ready_r <= 1'b0;
                  state_r <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               a_r     <= regs_r[rs_f_s[AW-1:0]];
               b_r     <= regs_r[rt_f_s[AW-1:0]];
               state_r <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               if (legal_s) begin
                  result_r   <= alu_res_s;
                  zero_r     <= (alu_res_s == {WIDTH{1'b0}});
                  overflow_r <= alu_ovf_s;
               end else begin
                  result_r   <= {WIDTH{1'b0}};
                  zero_r     <= 1'b1;
                  overflow_r <= 1'b0;
               end
               // done/illegal are high for exactly the WRITEBACK cycle
               done_r    <= 1'b1;
               illegal_r <= ~legal_s;
               state_r   <= ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Register file: one write port committed at the end of WRITEBACK; r0 never written
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {WIDTH{1'b0}};
         end
      end else if ((state_r == ST_WRITEBACK) && legal_s && (dest_s != ZERO_IDX)) begin
         regs_r[dest_s] <= result_r;
      end
   end

   assign bus.instr_ready = ready_r;
   assign bus.result      = result_r;
   assign bus.zero        = zero_r;
   assign bus.overflow    = overflow_r;
   assign bus.done        = done_r;
   assign bus.illegal     = illegal_r;
   assign bus.dbg_data    = regs_r[bus.dbg_addr[AW-1:0]];

endmodule

// File: tb/tb_mc_regalu_core.sv
// -----------------------------------------------------------------------------
// tb_mc_regalu_core
// Self-checking bench for mc_regalu_core. Three builds are instantiated:
// WIDTH=32/NREGS=32 (main), WIDTH=32/NREGS=8 and WIDTH=16/NREGS=32.
// Main-build expectations come from a reference model of the register file;
// each issued instruction pushes its expected result onto a queue that is
// popped when the core pulses done.
// -----------------------------------------------------------------------------
module tb_mc_regalu_core;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic        ill;
   } exp_t;

   localparam longint S32_MAX = 64'sd2147483647;
   localparam longint S32_MIN = -64'sd2147483648;

   logic clk;
   logic reset;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mregs [32];
   exp_t        exp_q [$];
   string       tag_q [$];
   exp_t        sb_e;
   string       sb_t;

   mc_regalu_core_if #(.WIDTH(32)) bus0  ();
   mc_regalu_core_if #(.WIDTH(32)) bus8  ();
   mc_regalu_core_if #(.WIDTH(16)) bus16 ();

   mc_regalu_core #(.WIDTH(32), .NREGS(32)) u_dut   (.clk(clk), .reset(reset), .bus(bus0));
   mc_regalu_core #(.WIDTH(32), .NREGS(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));
   mc_regalu_core #(.WIDTH(16), .NREGS(32)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Reference model: computes the expected outcome and updates mregs
   function automatic exp_t model_exec(input logic [31:0] ins, input logic [31:0] pc);
      exp_t        e;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] simm;
      logic [31:0] zimm;
      longint      s;
      int          dest;
      a     = mregs[ins[25:21]];
      b     = mregs[ins[20:16]];
      simm  = {{16{ins[15]}}, ins[15:0]};
      zimm  = {16'h0000, ins[15:0]};
      e     = '{res: 32'd0, zero: 1'b0, ovf: 1'b0, ill: 1'b0};
      dest  = 0;
      case (ins[31:26])
         6'h00: begin
            dest = int'(ins[15:11]);
            case (ins[5:0])
               6'h20: begin
                  s = longint'($signed(a)) + longint'($signed(b));
                  e.res = 32'(s);
                  e.ovf = (s > S32_MAX) || (s < S32_MIN);
               end
               6'h22: begin
                  s = longint'($signed(a)) - longint'($signed(b));
                  e.res = 32'(s);
                  e.ovf = (s > S32_MAX) || (s < S32_MIN);
               end
               6'h24:   e.res = a & b;
               6'h25:   e.res = a | b;
               6'h26:   e.res = a ^ b;
               6'h2A:   e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: e.ill = 1'b1;
            endcase
         end
         6'h08: begin
            dest = int'(ins[20:16]);
            s = longint'($signed(a)) + longint'($signed(simm));
            e.res = 32'(s);
            e.ovf = (s > S32_MAX) || (s < S32_MIN);
         end
         6'h0C: begin
            dest  = int'(ins[20:16]);
            e.res = a & zimm;
         end
         6'h0D: begin
            dest  = int'(ins[20:16]);
            e.res = a | zimm;
         end
         6'h03: begin
            dest  = 31;
            e.res = pc + 32'd4;
         end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) e.res = 32'd0;
      e.zero = (e.res == 32'd0);
      if (!e.ill && dest != 0) mregs[dest] = e.res;
      return e;
   endfunction

   // Scoreboard: pop and compare on every done pulse of the main build
   always @(negedge clk) begin
      if (!reset && bus0.done) begin
         check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            sb_t = tag_q.pop_front();
            check_val({sb_t, "_res"}, 64'(bus0.result), 64'(sb_e.res));
            check_val({sb_t, "_zero"}, 64'(bus0.zero), 64'(sb_e.zero));
            check_val({sb_t, "_ovf"}, 64'(bus0.overflow), 64'(sb_e.ovf));
            check_val({sb_t, "_ill"}, 64'(bus0.illegal), 64'(sb_e.ill));
         end
      end
      if (!reset && bus0.illegal) begin
         check_val("ill_with_done", 64'(bus0.done), 64'd1);
      end
   end

   // Issue one instruction to the main build and follow it through its 4 cycles
   task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] pc);
      int guard;
      @(negedge clk);
      guard = 0;
      while (bus0.instr_ready !== 1'b1 && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      check_val({tag, "_acc_rdy"}, 64'(bus0.instr_ready), 64'd1);
      exp_q.push_back(model_exec(ins, pc));
      tag_q.push_back(tag);
      bus0.instr_in    = ins;
      bus0.pc_in       = pc;
      bus0.instr_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         // valid stays high with junk while busy: the core must ignore it
         if (k == 1) begin
            bus0.instr_in = $urandom();
            bus0.pc_in    = $urandom();
         end
         if (k == 3) bus0.instr_valid = 1'b0;
         check_val($sformatf("%s_rdy%0d", tag, k), 64'(bus0.instr_ready), (k == 4) ? 64'd1 : 64'd0);
         check_val($sformatf("%s_done%0d", tag, k), 64'(bus0.done), (k == 3) ? 64'd1 : 64'd0);
      end
   endtask

   task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
      bus0.dbg_addr = 5'(idx);
      #1;
      check_val(tag, 64'(bus0.dbg_data), 64'(exp));
   endtask

   // Issue to one of the side builds (8 = NREGS 8, 16 = WIDTH 16) and wait for done
   task automatic issue_side(input int which, input logic [31:0] ins, input logic [31:0] pc);
      int   n;
      logic got;
      @(negedge clk);
      if (which == 8) begin
         bus8.instr_in = ins; bus8.pc_in = pc; bus8.instr_valid = 1'b1;
      end else begin
         bus16.instr_in = ins; bus16.pc_in = pc[15:0]; bus16.instr_valid = 1'b1;
      end
      @(negedge clk);
      bus8.instr_valid  = 1'b0;
      bus16.instr_valid = 1'b0;
      n   = 0;
      got = 1'b0;
      while (!got && n < 10) begin
         if ((which == 8) ? bus8.done : bus16.done) got = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      check_val($sformatf("side%0d_done", which), 64'(got), 64'd1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      bus0.instr_in = 32'd0;  bus0.instr_valid = 1'b0;  bus0.pc_in = 32'd0;  bus0.dbg_addr = 5'd0;
      bus8.instr_in = 32'd0;  bus8.instr_valid = 1'b0;  bus8.pc_in = 32'd0;  bus8.dbg_addr = 5'd0;
      bus16.instr_in = 32'd0; bus16.instr_valid = 1'b0; bus16.pc_in = 16'd0; bus16.dbg_addr = 5'd0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check_val("rst_ready", 64'(bus0.instr_ready), 64'd1);
      check_val("rst_result", 64'(bus0.result), 64'd0);
      check_val("rst_zero", 64'(bus0.zero), 64'd1);
      check_val("rst_ovf", 64'(bus0.overflow), 64'd0);
      check_val("rst_done", 64'(bus0.done), 64'd0);
      check_val("rst_ill", 64'(bus0.illegal), 64'd0);
      check_reg("rst_r31", 31, 32'd0);

      // Immediate loads
      issue("addi_r1", enc_i(6'h08, 5'd1, 5'd0, 16'd5), 32'd0);
      check_reg("r1_eq5", 1, 32'd5);
      issue("addi_r2", enc_i(6'h08, 5'd2, 5'd0, 16'hFFFD), 32'd0);
      check_reg("r2_eqm3", 2, 32'hFFFF_FFFD);

      // R-type operations
      issue("add_r3", enc_r(5'd3, 5'd1, 5'd2, 6'h20), 32'd0);
      check_val("add_r3_const", 64'(bus0.result), 64'd2);
      issue("sub_r4", enc_r(5'd4, 5'd2, 5'd1, 6'h22), 32'd0);
      check_val("sub_r4_const", 64'(bus0.result), 64'hFFFF_FFF8);
      issue("slt_r5", enc_r(5'd5, 5'd2, 5'd1, 6'h2A), 32'd0);
      check_val("slt_r5_const", 64'(bus0.result), 64'd1);
      issue("sub_r6", enc_r(5'd6, 5'd1, 5'd1, 6'h22), 32'd0);
      check_val("sub_r6_zero", 64'(bus0.zero), 64'd1);
      issue("slt_r17", enc_r(5'd17, 5'd1, 5'd2, 6'h2A), 32'd0);
      issue("and_r15", enc_r(5'd15, 5'd1, 5'd2, 6'h24), 32'd0);
      issue("or_r16", enc_r(5'd16, 5'd1, 5'd2, 6'h25), 32'd0);
      issue("xor_r14", enc_r(5'd14, 5'd1, 5'd2, 6'h26), 32'd0);
      issue("andi_r12", enc_i(6'h0C, 5'd12, 5'd2, 16'hFF00), 32'd0);
      check_reg("r12_andi", 12, 32'h0000_FF00);
      issue("ori_r13", enc_i(6'h0D, 5'd13, 5'd1, 16'hF000), 32'd0);
      check_reg("r13_ori", 13, 32'h0000_F005);
      issue("addi_r18", enc_i(6'h08, 5'd18, 5'd0, 16'h8000), 32'd0);
      check_reg("r18_sext", 18, 32'hFFFF_8000);

      // Build r9 = 0x80000000 and r7 = 0x7FFFFFFF, then overflow cases
      issue("ori_r9", enc_i(6'h0D, 5'd9, 5'd0, 16'h8000), 32'd0);
      for (int i = 0; i < 16; i++) issue($sformatf("dbl%0d", i), enc_r(5'd9, 5'd9, 5'd9, 6'h20), 32'd0);
      check_reg("r9_min", 9, 32'h8000_0000);
      issue("addi_r7", enc_i(6'h08, 5'd7, 5'd0, 16'hFFFF), 32'd0);
      issue("xor_r7", enc_r(5'd7, 5'd7, 5'd9, 6'h26), 32'd0);
      check_reg("r7_max", 7, 32'h7FFF_FFFF);
      issue("add_r8", enc_r(5'd8, 5'd7, 5'd7, 6'h20), 32'd0);
      check_val("add_r8_ovf", 64'(bus0.overflow), 64'd1);
      check_reg("r8_written", 8, 32'hFFFF_FFFE);
      issue("sub_r10", enc_r(5'd10, 5'd9, 5'd1, 6'h22), 32'd0);
      issue("addi_r11", enc_i(6'h08, 5'd11, 5'd7, 16'd1), 32'd0);
      issue("add_r19", enc_r(5'd19, 5'd9, 5'd9, 6'h20), 32'd0);

      // jal link and PC wrap
      issue("jal_100", {6'h03, 26'h000_0040}, 32'h0000_0100);
      check_reg("r31_link", 31, 32'h0000_0104);
      issue("jal_wrap", {6'h03, 26'h000_0000}, 32'hFFFF_FFFC);
      check_reg("r31_wrap", 31, 32'd0);

      // Illegal encodings and r0 write drop
      issue("ill_op", {6'h3F, 5'd2, 5'd1, 16'h1234}, 32'd0);
      issue("ill_fn", enc_r(5'd3, 5'd1, 5'd2, 6'h21), 32'd0);
      for (int i = 0; i < 32; i++) check_reg($sformatf("keep_r%0d", i), i, mregs[i]);
      issue("addi_r0", enc_i(6'h08, 5'd0, 5'd0, 16'd9), 32'd0);
      check_reg("r0_zero", 0, 32'd0);

      // NREGS = 8: jal links to r7, index wraps to low 3 bits
      issue_side(8, {6'h03, 26'h000_0000}, 32'h0000_0100);
      bus8.dbg_addr = 5'd7;  #1;
      check_val("n8_r7", 64'(bus8.dbg_data), 64'h104);
      bus8.dbg_addr = 5'd31; #1;
      check_val("n8_r31_alias", 64'(bus8.dbg_data), 64'h104);
      issue_side(8, enc_i(6'h08, 5'd9, 5'd0, 16'd3), 32'd0);
      bus8.dbg_addr = 5'd1;  #1;
      check_val("n8_r9_to_r1", 64'(bus8.dbg_data), 64'd3);

      // WIDTH = 16
      issue_side(16, enc_i(6'h08, 5'd1, 5'd0, 16'hFFFF), 32'd0);
      bus16.dbg_addr = 5'd1; #1;
      check_val("w16_r1", 64'(bus16.dbg_data), 64'hFFFF);
      check_val("w16_ovf0", 64'(bus16.overflow), 64'd0);
      issue_side(16, enc_i(6'h08, 5'd2, 5'd1, 16'h8000), 32'd0);
      check_val("w16_res", 64'(bus16.result), 64'h7FFF);
      check_val("w16_ovf1", 64'(bus16.overflow), 64'd1);

      // Reset during EXECUTE of addi r1,r0,7
      @(negedge clk);
      bus0.instr_in = enc_i(6'h08, 5'd1, 5'd0, 16'd7);
      bus0.pc_in = 32'd0;
      bus0.instr_valid = 1'b1;
      @(negedge clk);
      bus0.instr_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("abort_ready", 64'(bus0.instr_ready), 64'd1);
      check_val("abort_done", 64'(bus0.done), 64'd0);
      check_val("abort_ill", 64'(bus0.illegal), 64'd0);
      check_val("abort_zero", 64'(bus0.zero), 64'd1);
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_val($sformatf("abort_nodone%0d", k), 64'(bus0.done), 64'd0);
      end
      check_reg("abort_r1", 1, 32'd0);
      issue("addi_r1_7", enc_i(6'h08, 5'd1, 5'd0, 16'd7), 32'd0);
      check_reg("r1_eq7", 1, 32'd7);

      repeat (2) @(negedge clk);
      check_val("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
